// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: fetches 1- or 2-byte instructions over a shared read bus.
// Optional memory-request timeout is enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch_ctrl #(
  parameter int unsigned PC_W      = 8,
  parameter logic [7:0]  OPND_MASK = 8'hF0,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic            mem_ack,
  input  logic [7:0]      bus_data,
  input  logic            exec_done,
  input  logic            jump,
  input  logic [PC_W-1:0] jump_addr,
  output logic            mem_req,
  output logic [PC_W-1:0] mem_addr,
  output logic [1:0]      fetch,
  output logic            ins_valid,
  output logic            busy,
  output logic            fetch_err
);

  localparam int unsigned     TO_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    F1   = 3'd1,
    F2   = 3'd2,
    EXEC = 3'd3,
    ERR  = 3'd4
  } state_t;

  // state, pc and to_cnt are kept as plain named signals so checkers can bind to them.
  state_t          state, state_next;
  logic [PC_W-1:0] pc, pc_next;
  logic [TO_W-1:0] to_cnt, to_next, to_inc;
  logic [2:0]      opcode;
  logic            opnd_needed;
  logic            timeout_hit;
  logic [4:0]      unused_bus_bits;

  // Handshake: mem_req is held high for the whole F1/F2 state; a byte is taken
  // in the cycle mem_ack is high, and mem_ack is ignored while mem_req is low.
  assign opcode          = bus_data[7:5];
  assign unused_bus_bits = bus_data[4:0];
  assign opnd_needed     = OPND_MASK[opcode];
  assign to_inc          = to_cnt + 1'b1;

`ifdef FETCH_TIMEOUT_EN
  assign timeout_hit = (to_inc == TO_MAX);
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      pc     <= '0;
      to_cnt <= '0;
    end else begin
      state  <= state_next;
      pc     <= pc_next;
      to_cnt <= to_next;
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    to_next    = to_cnt;
    fetch      = 2'b00;
    case (state)
      IDLE: begin
        if (run) begin
          state_next = F1;
          to_next    = '0;
        end
      end
      F1: begin
        if (mem_ack) begin
          fetch      = 2'b01;
          pc_next    = pc + 1'b1;
          to_next    = '0;
          state_next = opnd_needed ? F2 : EXEC;
        end else begin
          // Wait counter saturates; it only forces ERR when the timeout is built in.
          if (to_cnt != TO_MAX) to_next = to_inc;
          if (timeout_hit) state_next = ERR;
        end
      end
      F2: begin
        if (mem_ack) begin
          fetch      = 2'b10;
          pc_next    = pc + 1'b1;
          to_next    = '0;
          state_next = EXEC;
        end else begin
          if (to_cnt != TO_MAX) to_next = to_inc;
          if (timeout_hit) state_next = ERR;
        end
      end
      EXEC: begin
        if (exec_done) begin
          if (jump) pc_next = jump_addr;
          if (run) begin
            state_next = F1;
            to_next    = '0;
          end else begin
            state_next = IDLE;
          end
        end
      end
      ERR: begin
        if (!run) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign mem_req   = (state == F1) || (state == F2);
  assign mem_addr  = pc;
  assign ins_valid = (state == EXEC);
  assign busy      = (state != IDLE);

`ifdef FETCH_TIMEOUT_EN
  assign fetch_err = (state == ERR);
`else
  assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl: linear step sequence with immediate-assertion checks.
module tb_instr_fetch_ctrl;

  logic       clk;
  logic       rst;
  logic       run;
  logic       mem_ack;
  logic [7:0] bus_data;
  logic       exec_done;
  logic       jump;
  logic [7:0] jump_addr;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic [1:0] fetch;
  logic       ins_valid;
  logic       busy;
  logic       fetch_err;

  int n_cmp;
  int n_err;

  instr_fetch_ctrl #(.PC_W(8), .OPND_MASK(8'hF0), .TIMEOUT(15)) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .mem_ack   (mem_ack),
    .bus_data  (bus_data),
    .exec_done (exec_done),
    .jump      (jump),
    .jump_addr (jump_addr),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .fetch     (fetch),
    .ins_valid (ins_valid),
    .busy      (busy),
    .fetch_err (fetch_err)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver helpers: inputs change 2 time units after a rising edge, outputs are checked 1 unit later.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic rq, input logic [7:0] ad,
                          input logic [1:0] fe, input logic iv, input logic bz);
    chk({tag, ".mem_req"},   32'(mem_req),   32'(rq));
    chk({tag, ".mem_addr"},  32'(mem_addr),  32'(ad));
    chk({tag, ".fetch"},     32'(fetch),     32'(fe));
    chk({tag, ".ins_valid"}, 32'(ins_valid), 32'(iv));
    chk({tag, ".busy"},      32'(busy),      32'(bz));
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst       = 1'b0;
    run       = 1'b0;
    mem_ack   = 1'b0;
    bus_data  = 8'h00;
    exec_done = 1'b0;
    jump      = 1'b0;
    jump_addr = 8'h00;

    // Reset state
    step();
    settle();
    chk_outs("reset", 1'b0, 8'h00, 2'b00, 1'b0, 1'b0);
    chk("reset.fetch_err", 32'(fetch_err), 32'h0);
    rst = 1'b1;
    step();

    // 1-byte instruction (opcode 1): run sampled at edge A, F1 ack, EXEC after edge B
    run = 1'b1;
    settle();
    chk_outs("idle_run", 1'b0, 8'h00, 2'b00, 1'b0, 1'b0);
    step();
    mem_ack  = 1'b1;
    bus_data = 8'h25;
    settle();
    chk_outs("f1_1byte", 1'b1, 8'h00, 2'b01, 1'b0, 1'b1);
    step();
    mem_ack = 1'b0;
    settle();
    chk_outs("exec_1byte", 1'b0, 8'h01, 2'b00, 1'b1, 1'b1);
    mem_ack = 1'b1;
    settle();
    chk("exec_ack_ignored.fetch", 32'(fetch), 32'h0);
    step();
    mem_ack = 1'b0;
    settle();
    chk_outs("exec_hold", 1'b0, 8'h01, 2'b00, 1'b1, 1'b1);

    // 2-byte instruction (opcode 5) with one wait cycle in F1
    exec_done = 1'b1;
    step();
    exec_done = 1'b0;
    settle();
    chk_outs("f1_wait", 1'b1, 8'h01, 2'b00, 1'b0, 1'b1);
    step();
    mem_ack  = 1'b1;
    bus_data = 8'hA3;
    settle();
    chk_outs("f1_2byte", 1'b1, 8'h01, 2'b01, 1'b0, 1'b1);
    step();
    bus_data = 8'h7E;
    settle();
    chk_outs("f2_2byte", 1'b1, 8'h02, 2'b10, 1'b0, 1'b1);
    step();
    mem_ack = 1'b0;
    settle();
    chk_outs("exec_2byte", 1'b0, 8'h03, 2'b00, 1'b1, 1'b1);

    // Jump to 8'h40
    exec_done = 1'b1;
    jump      = 1'b1;
    jump_addr = 8'h40;
    step();
    exec_done = 1'b0;
    jump      = 1'b0;
    settle();
    chk_outs("jump_f1", 1'b1, 8'h40, 2'b00, 1'b0, 1'b1);
    mem_ack  = 1'b1;
    bus_data = 8'h25;
    step();
    mem_ack = 1'b0;
    settle();
    chk_outs("jump_exec", 1'b0, 8'h41, 2'b00, 1'b1, 1'b1);

    // Wrap: jump to 8'hFF, 2-byte opcode 7, operand at 8'h00
    exec_done = 1'b1;
    jump      = 1'b1;
    jump_addr = 8'hFF;
    step();
    exec_done = 1'b0;
    jump      = 1'b0;
    mem_ack   = 1'b1;
    bus_data  = 8'hE0;
    settle();
    chk_outs("wrap_f1", 1'b1, 8'hFF, 2'b01, 1'b0, 1'b1);
    step();
    bus_data = 8'h11;
    settle();
    chk_outs("wrap_f2", 1'b1, 8'h00, 2'b10, 1'b0, 1'b1);
    step();
    mem_ack = 1'b0;
    settle();
    chk_outs("wrap_exec", 1'b0, 8'h01, 2'b00, 1'b1, 1'b1);

    // run dropped during F1/F2 still completes the instruction, then IDLE
    exec_done = 1'b1;
    step();
    exec_done = 1'b0;
    run       = 1'b0;
    mem_ack   = 1'b1;
    bus_data  = 8'hA3;
    settle();
    chk_outs("norun_f1", 1'b1, 8'h01, 2'b01, 1'b0, 1'b1);
    step();
    settle();
    chk_outs("norun_f2", 1'b1, 8'h02, 2'b10, 1'b0, 1'b1);
    step();
    mem_ack = 1'b0;
    settle();
    chk_outs("norun_exec", 1'b0, 8'h03, 2'b00, 1'b1, 1'b1);
    exec_done = 1'b1;
    step();
    exec_done = 1'b0;
    settle();
    chk_outs("norun_idle", 1'b0, 8'h03, 2'b00, 1'b0, 1'b0);

    // Reset asserted in F2
    run = 1'b1;
    step();
    mem_ack  = 1'b1;
    bus_data = 8'hA3;
    step();
    mem_ack = 1'b0;
    settle();
    chk_outs("pre_reset_f2", 1'b1, 8'h04, 2'b00, 1'b0, 1'b1);
    rst = 1'b0;
    settle();
    chk_outs("reset_mid_f2", 1'b0, 8'h00, 2'b00, 1'b0, 1'b0);
    chk("reset_mid_f2.fetch_err", 32'(fetch_err), 32'h0);
    run = 1'b0;
    step();
    rst = 1'b1;
    step();
    settle();
    chk_outs("post_reset_idle", 1'b0, 8'h00, 2'b00, 1'b0, 1'b0);

    // First request one cycle after run is sampled
    run = 1'b1;
    settle();
    chk("first_req_before.mem_req", 32'(mem_req), 32'h0);
    step();
    settle();
    chk_outs("first_req", 1'b1, 8'h00, 2'b00, 1'b0, 1'b1);

`ifdef FETCH_TIMEOUT_EN
    // 15 wait cycles in F1 lead to ERR; run=0 returns to IDLE
    for (int i = 0; i < 14; i++) step();
    settle();
    chk_outs("to_before", 1'b1, 8'h00, 2'b00, 1'b0, 1'b1);
    chk("to_before.fetch_err", 32'(fetch_err), 32'h0);
    step();
    settle();
    chk_outs("to_err", 1'b0, 8'h00, 2'b00, 1'b0, 1'b1);
    chk("to_err.fetch_err", 32'(fetch_err), 32'h1);
    run = 1'b0;
    step();
    settle();
    chk_outs("to_idle", 1'b0, 8'h00, 2'b00, 1'b0, 1'b0);
    chk("to_idle.fetch_err", 32'(fetch_err), 32'h0);
`else
    // Without the timeout, F1 waits indefinitely and fetch_err stays 0
    for (int i = 0; i < 20; i++) step();
    settle();
    chk_outs("no_to_wait", 1'b1, 8'h00, 2'b00, 1'b0, 1'b1);
    chk("no_to_wait.fetch_err", 32'(fetch_err), 32'h0);
    mem_ack  = 1'b1;
    bus_data = 8'h25;
    step();
    mem_ack = 1'b0;
    settle();
    chk_outs("no_to_exec", 1'b0, 8'h01, 2'b00, 1'b1, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch_ctrl.md
INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- PC_W, 8, program counter and memory address width.
- OPND_MASK, 8'hF0, bit k set means opcode k needs a second (operand) byte.
- TIMEOUT, 15, wait cycles allowed per memory request (used only with the Configuration macro).
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, clock; all state updates on its rising edge.
- rst, in, 1, asynchronous, active-low reset.
- run, in, 1, enables instruction fetching.
- mem_ack, in, 1, memory read data is valid on bus_data this cycle.
- bus_data, in, 8, shared read bus; bits [7:5] are the opcode.
- exec_done, in, 1, execute unit has finished with the current instruction.
- jump, in, 1, qualifies exec_done; load the PC from jump_addr.
- jump_addr, in, PC_W, branch target.
- mem_req, out, 1, memory read request.
- mem_addr, out, PC_W, read address (the current PC).
- fetch, out, 2, capture strobe to the instruction register: 01 = opcode byte, 10 = operand byte, 00 = hold.
- ins_valid, out, 1, instruction register holds a complete instruction.
- busy, out, 1, high in any state other than IDLE.
- fetch_err, out, 1, memory request timed out.

Function
REQ-003 The FSM SHALL have these states: IDLE, F1 (opcode fetch), F2 (operand fetch), EXEC and ERR.
REQ-004 IDLE behaviour:
- With run=1, the next state SHALL be F1.
- With run=0, the FSM SHALL stay in IDLE.
REQ-005 In F1 and F2, mem_req SHALL be 1 and mem_addr SHALL equal the PC.
- In every other state, mem_req SHALL be 0.
- mem_addr SHALL always equal the PC.
REQ-006 In F1 with mem_ack=1, the block SHALL act in that same cycle:
- drive fetch=01 combinationally;
- increment the PC at the clock edge;
- go to F2 if OPND_MASK[bus_data[7:5]]=1, else go to EXEC.
REQ-007 In F2 with mem_ack=1, fetch SHALL be 10 in that cycle, the PC SHALL increment, and the next state SHALL be EXEC.
REQ-008 In any cycle not covered by REQ-006 or REQ-007, fetch SHALL be 00.
- mem_ack SHALL be ignored outside F1 and F2.
REQ-009 In EXEC, ins_valid SHALL be 1.
- On exec_done=1 with jump=1, the PC SHALL load jump_addr; otherwise the PC SHALL hold.
- On exec_done=1, the next state SHALL be F1 if run=1, else IDLE.
REQ-010 Deasserting run during F1 or F2 SHALL NOT abort the fetch; the instruction SHALL complete through EXEC first.
REQ-011 The PC SHALL wrap modulo 2^PC_W (all-ones + 1 = 0), including between the opcode and operand bytes.
REQ-012 Latency with zero-wait memory: ins_valid SHALL rise 2 cycles after run is sampled in IDLE for a 1-byte instruction, and 3 cycles after for a 2-byte instruction.
REQ-013 The outputs mem_req, ins_valid, busy and fetch_err SHALL be pure decodes of the state; only fetch also depends on mem_ack.

Reset
REQ-014 With rst=0, asynchronously and at any point in operation:
- state SHALL be IDLE;
- PC SHALL be 0;
- the timeout counter SHALL be 0;
- mem_req, fetch, ins_valid, busy and fetch_err SHALL all be 0.
REQ-015 After rst is released, the first possible mem_req SHALL come one cycle after run=1 is sampled.

Configuration
REQ-016 The macro FETCH_TIMEOUT_EN SHALL control the memory-request timeout.
- Defined:
  - a counter SHALL clear on entering F1 or F2 and increment each F1/F2 cycle with mem_ack=0;
  - when the counter reaches TIMEOUT, the next state SHALL be ERR;
  - in ERR, fetch_err SHALL be 1 and mem_req SHALL be 0;
  - ERR SHALL exit to IDLE when run=0;
  - the PC SHALL be unchanged by a timeout.
- Not defined:
  - F1 and F2 SHALL wait indefinitely;
  - ERR SHALL be unreachable;
  - fetch_err SHALL be constant 0.

Verification
REQ-017 The bench SHALL cover these directed scenarios (stimulus -> required response):
- 1-byte instruction: reset, run=1, ack in the first F1 cycle, bus_data=8'h25 -> fetch=01 for one cycle; ins_valid high 2 cycles after run; PC=1.
- 2-byte instruction: bus_data=8'hA3, then 8'h7E, ack on each first cycle -> fetch=01 then 10 in consecutive cycles; ins_valid at cycle 3; PC=2.
- Jump: in EXEC, exec_done=1, jump=1, jump_addr=8'h40 -> next F1 with mem_addr=8'h40.
- Wrap: PC=8'hFF, 2-byte opcode -> operand fetched at mem_addr=8'h00; PC ends at 8'h01.
- Reset mid-fetch: rst=0 while in F2 -> all outputs 0 immediately; PC=0; IDLE.
- With FETCH_TIMEOUT_EN, TIMEOUT=15, no ack -> fetch_err=1 after 15 wait cycles; mem_req=0; run=0 returns to IDLE.
